multi_channel_timer: RTL and testbench
======================================

// Module: multi_channel_timer
// PURPOSE
//  Parametrised system tick source: NUM_CH independent interval timers, each
//  with its own period, periodic/one-shot mode and IRQ/IACK/IEND handshake.
//  Sits between CPU config bus and interrupt controller; one IRQ line per channel.
//  Adds runtime reprogramming and overrun detection.
// PARAMETERS
//  NUM_CH          4        number of channels (>=2)
//  CNT_W           32       counter/period width
//  DEFAULT_PERIOD  500000   per-channel period loaded at reset (clocks)
//  RESET_EN_MASK   4'b0001  channels enabled at reset (bit i = channel i)
//  PRESCALE_DIV    1        prescaler divide ratio (used only with TIMER_PRESCALER_EN)
// PORTS
//  CLK          in   1                 clock
//  RESET        in   1                 synchronous, active-high reset
//  CFG_WE       in   1                 config write strobe (one cycle)
//  CFG_CH       in   $clog2(NUM_CH)    channel addressed by write
//  CFG_PERIOD   in   CNT_W             period in ticks; 0 = channel halted
//  CFG_ONESHOT  in   1                 1 = one-shot, 0 = periodic
//  CFG_EN       in   1                 channel enable
//  INTC_IRQ     out  NUM_CH            interrupt request per channel
//  INTC_IACK    in   NUM_CH            acknowledge per channel
//  INTC_IEND    in   NUM_CH            end-of-service per channel
//  OVERRUN      out  NUM_CH            sticky: tick occurred while IRQ pending/in service
// BEHAVIOUR
//  Reset: counters=0, period=DEFAULT_PERIOD, periodic mode, EN=RESET_EN_MASK[i],
//   state=ARMED if enabled else IDLE; INTC_IRQ=0, OVERRUN=0.
//  Counter: runs while EN && period!=0, in every state except IDLE; counts 0..period-1,
//   wraps to 0. "Tick" = cycle where counter==period-1. Period 1 -> tick every cycle.
//  Per-channel FSM (INTC_IRQ[i] = registered decode of state==REQ):
//   IDLE    : counter held at 0, no ticks; leave only via config write with EN=1.
//   ARMED   : tick -> REQ.
//   REQ     : IRQ=1; IACK -> SERVICE. IEND ignored (IACK+IEND same cycle -> SERVICE only).
//   SERVICE : IEND -> ARMED (periodic) or IDLE with EN cleared (one-shot). IACK ignored.
//  Latency: tick in cycle N -> INTC_IRQ high in N+1; IACK sampled in N -> IRQ low in N+1.
//  Counter keeps running through REQ/SERVICE (fixed rate, no drift); next IRQ only on a
//   tick seen in ARMED.
//  Overrun: tick while in REQ or SERVICE sets OVERRUN[i]; cleared by config write to
//   channel i or RESET. Missed tick is not queued.
//  Config write (CFG_WE=1, CFG_CH<NUM_CH): loads period/mode/EN, counter<=0, OVERRUN<=0,
//   state<=ARMED if CFG_EN && CFG_PERIOD!=0 else IDLE; pending IRQ dropped next cycle.
//   CFG_CH>=NUM_CH: write ignored. Write coinciding with tick/IACK/IEND: write wins.
//  RESET mid-handshake: IRQ drops next cycle, all channels return to reset config.
//  Channels fully independent; no arbitration or priority inside this block.
// CONFIGURATION
//  TIMER_PRESCALER_EN defined: shared prescaler counts 0..PRESCALE_DIV-1; channel
//   counters advance only on the prescaler wrap cycle (tick period = period*PRESCALE_DIV
//   clocks). Prescaler reset by RESET only, not by config writes.
//  Not defined: counters advance every CLK; PRESCALE_DIV ignored.
// TESTING
//  Reset, default params, ch0 only: IRQ[0] rises at cycle 500000 after reset release;
//   IRQ[3:1] stay 0.
//  Write ch1 period=10 periodic EN; IACK 2 cycles after IRQ, IEND 3 cycles later ->
//   IRQ[1] rises every 10 cycles, IRQ low cycle after IACK, OVERRUN[1]=0.
//  Ch2 period=5 one-shot: one IRQ after 5 cycles; after IEND no further IRQ for 100
//   cycles; channel in IDLE.
//  Ch1 period=4, hold IACK off for 12 cycles -> single IRQ held high, OVERRUN[1]=1;
//   config write to ch1 -> OVERRUN[1]=0, IRQ[1] low.
//  IACK and IEND together in REQ -> SERVICE only; separate IEND later needed to re-arm.
//  Assert RESET during SERVICE on ch0 -> IRQ=0, OVERRUN=0, next IRQ[0] after full
//   DEFAULT_PERIOD; CFG_CH out of range with NUM_CH=3 -> no channel changes.

Source files
------------

// File: rtl/multi_channel_timer.sv
// NUM_CH independent interval timers with IRQ/IACK/IEND handshake and sticky overrun flags.
// Optional shared prescaler enabled by defining TIMER_PRESCALER_EN.
module multi_channel_timer #(
    parameter int                NUM_CH         = 4,
    parameter int                CNT_W          = 32,
    parameter int                DEFAULT_PERIOD = 500000,
    parameter logic [NUM_CH-1:0] RESET_EN_MASK  = {{(NUM_CH-1){1'b0}}, 1'b1},
    parameter int                PRESCALE_DIV   = 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      CFG_WE,
    input  logic [$clog2(NUM_CH)-1:0] CFG_CH,
    input  logic [CNT_W-1:0]          CFG_PERIOD,
    input  logic                      CFG_ONESHOT,
    input  logic                      CFG_EN,
    output logic [NUM_CH-1:0]         INTC_IRQ,
    input  logic [NUM_CH-1:0]         INTC_IACK,
    input  logic [NUM_CH-1:0]         INTC_IEND,
    output logic [NUM_CH-1:0]         OVERRUN
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_REQ,
        ST_SERVICE
    } state_t;

    // Counter advance strobe shared by all channels.
    logic adv;

`ifdef TIMER_PRESCALER_EN
    localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    logic [PRE_W-1:0] pre_q;

    assign adv = (pre_q == PRE_W'(PRESCALE_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RESET || adv) pre_q <= '0;
        else              pre_q <= pre_q + PRE_W'(1);
    end
`else
    assign adv = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] period_q, period_d;
        logic             oneshot_q, oneshot_d;
        logic             en_q, en_d;
        logic             ovr_q, ovr_d;
        logic             irq_q;
        logic             cfg_hit;
        logic             run;
        logic             tick;

        // CFG_CH values >= NUM_CH never match any channel index, so they are dropped.
        assign cfg_hit = CFG_WE && (CFG_CH == CH_W'(i));
        assign run     = en_q && (period_q != '0) && (state_q != ST_IDLE);
        assign tick    = run && adv && (cnt_q == period_q - CNT_W'(1));

        always_comb begin
            // NOTE: every signal written here gets a default first, so no path can infer a latch.
            state_d   = state_q;
            cnt_d     = cnt_q;
            period_d  = period_q;
            oneshot_d = oneshot_q;
            en_d      = en_q;
            ovr_d     = ovr_q;

            if (run && adv) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

            unique case (state_q)
                ST_IDLE: cnt_d = '0;
                ST_ARMED: begin
                    if (tick) state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (tick)         ovr_d   = 1'b1;
                    if (INTC_IACK[i]) state_d = ST_SERVICE;
                end
                ST_SERVICE: begin
                    if (tick) ovr_d = 1'b1;
                    if (INTC_IEND[i]) begin
                        if (oneshot_q) begin
                            state_d = ST_IDLE;
                            en_d    = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // A config write overrides any handshake or tick in the same cycle.
            if (cfg_hit) begin
                period_d  = CFG_PERIOD;
                oneshot_d = CFG_ONESHOT;
                en_d      = CFG_EN;
                cnt_d     = '0;
                ovr_d     = 1'b0;
                state_d   = (CFG_EN && (CFG_PERIOD != '0)) ? ST_ARMED : ST_IDLE;
            end
        end

        // IRQ decodes the next state so it rises the cycle after the tick.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                state_q   <= RESET_EN_MASK[i] ? ST_ARMED : ST_IDLE;
                cnt_q     <= '0;
                period_q  <= CNT_W'(DEFAULT_PERIOD);
                oneshot_q <= 1'b0;
                en_q      <= RESET_EN_MASK[i];
                ovr_q     <= 1'b0;
                irq_q     <= 1'b0;
            end else begin
                // NOTE: registers use non-blocking assignment so all channels update from the same pre-edge values.
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                period_q  <= period_d;
                oneshot_q <= oneshot_d;
                en_q      <= en_d;
                ovr_q     <= ovr_d;
                irq_q     <= (state_d == ST_REQ);
            end
        end

        assign INTC_IRQ[i] = irq_q;
        assign OVERRUN[i]  = ovr_q;
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer: 3 channels, 20-clock default period, ch0 enabled at reset.
module tb_multi_channel_timer;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int DEF_P  = 20;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              CFG_WE = 1'b0;
    logic [1:0]        CFG_CH = '0;
    logic [CNT_W-1:0]  CFG_PERIOD = '0;
    logic              CFG_ONESHOT = 1'b0;
    logic              CFG_EN = 1'b0;
    logic [NUM_CH-1:0] INTC_IRQ;
    logic [NUM_CH-1:0] INTC_IACK = '0;
    logic [NUM_CH-1:0] INTC_IEND = '0;
    logic [NUM_CH-1:0] OVERRUN;

    int total = 0;
    int bad   = 0;

    multi_channel_timer #(
        .NUM_CH        (NUM_CH),
        .CNT_W         (CNT_W),
        .DEFAULT_PERIOD(DEF_P),
        .RESET_EN_MASK (3'b001),
        .PRESCALE_DIV  (1)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CFG_WE     (CFG_WE),
        .CFG_CH     (CFG_CH),
        .CFG_PERIOD (CFG_PERIOD),
        .CFG_ONESHOT(CFG_ONESHOT),
        .CFG_EN     (CFG_EN),
        .INTC_IRQ   (INTC_IRQ),
        .INTC_IACK  (INTC_IACK),
        .INTC_IEND  (INTC_IEND),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input int ch, input int p, input bit os, input bit en);
        CFG_WE      = 1'b1;
        CFG_CH      = 2'(ch);
        CFG_PERIOD  = CNT_W'(p);
        CFG_ONESHOT = os;
        CFG_EN      = en;
        step();
        CFG_WE      = 1'b0;
    endtask

    task automatic ack(input int ch);
        INTC_IACK[ch] = 1'b1;
        step();
        INTC_IACK[ch] = 1'b0;
    endtask

    task automatic iend(input int ch);
        INTC_IEND[ch] = 1'b1;
        step();
        INTC_IEND[ch] = 1'b0;
    endtask

    // Steps until IRQ[ch] is high; n is the number of steps taken (== limit on timeout).
    task automatic wait_rise(input int ch, input int limit, output int n);
        n = 0;
        while (!INTC_IRQ[ch] && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        RESET = 1'b1;
        step();
        step();
        total++;
        if (INTC_IRQ !== 3'b000) begin bad++; $display("FAIL reset_irq got=%b want=000", INTC_IRQ); end
        total++;
        if (OVERRUN !== 3'b000) begin bad++; $display("FAIL reset_overrun got=%b want=000", OVERRUN); end
        RESET = 1'b0;
        wait_rise(0, DEF_P + 10, n);
        total++;
        if (n != DEF_P) begin bad++; $display("FAIL reset_first_irq_cycle got=%0d want=%0d", n, DEF_P); end
        total++;
        if (INTC_IRQ[2:1] !== 2'b00) begin bad++; $display("FAIL reset_other_irq got=%b want=00", INTC_IRQ[2:1]); end
        ack(0);
        iend(0);
        cfg(0, DEF_P, 1'b0, 1'b0);
    endtask

    task automatic test_periodic();
        int n;
        cfg(1, 10, 1'b0, 1'b1);
        wait_rise(1, 20, n);
        total++;
        if (n != 10) begin bad++; $display("FAIL periodic_first_irq got=%0d want=10", n); end
        for (int k = 0; k < 2; k++) begin
            step();
            step();
            ack(1);
            total++;
            if (INTC_IRQ[1] !== 1'b0) begin bad++; $display("FAIL periodic_irq_after_iack got=%b want=0", INTC_IRQ[1]); end
            step();
            step();
            iend(1);
            wait_rise(1, 20, n);
            total++;
            if (n != 4) begin bad++; $display("FAIL periodic_next_irq got=%0d want=4", n); end
        end
        total++;
        if (OVERRUN[1] !== 1'b0) begin bad++; $display("FAIL periodic_overrun got=%b want=0", OVERRUN[1]); end
        cfg(1, 10, 1'b0, 1'b0);
    endtask

    task automatic test_oneshot();
        int n;
        bit seen;
        cfg(2, 5, 1'b1, 1'b1);
        wait_rise(2, 20, n);
        total++;
        if (n != 5) begin bad++; $display("FAIL oneshot_irq got=%0d want=5", n); end
        ack(2);
        iend(2);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (INTC_IRQ[2]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL oneshot_rearmed got=%b want=0", seen); end
        total++;
        if (OVERRUN[2] !== 1'b0) begin bad++; $display("FAIL oneshot_overrun got=%b want=0", OVERRUN[2]); end
    endtask

    task automatic test_overrun();
        int n;
        bit dropped;
        cfg(1, 4, 1'b0, 1'b1);
        wait_rise(1, 20, n);
        total++;
        if (n != 4) begin bad++; $display("FAIL overrun_first_irq got=%0d want=4", n); end
        dropped = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (!INTC_IRQ[1]) dropped = 1'b1;
            if (k == 3) begin
                total++;
                if (OVERRUN[1] !== 1'b0) begin bad++; $display("FAIL overrun_early got=%b want=0", OVERRUN[1]); end
            end
            if (k == 4) begin
                total++;
                if (OVERRUN[1] !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", OVERRUN[1]); end
            end
        end
        total++;
        if (dropped !== 1'b0) begin bad++; $display("FAIL overrun_irq_held got=%b want=0", dropped); end
        cfg(1, 4, 1'b0, 1'b1);
        total++;
        if (OVERRUN[1] !== 1'b0) begin bad++; $display("FAIL overrun_cleared got=%b want=0", OVERRUN[1]); end
        total++;
        if (INTC_IRQ[1] !== 1'b0) begin bad++; $display("FAIL overrun_irq_dropped got=%b want=0", INTC_IRQ[1]); end
        cfg(1, 4, 1'b0, 1'b0);
    endtask

    task automatic test_ack_end_together();
        int n;
        bit seen;
        cfg(1, 6, 1'b0, 1'b1);
        wait_rise(1, 20, n);
        total++;
        if (n != 6) begin bad++; $display("FAIL both_first_irq got=%0d want=6", n); end
        INTC_IACK[1] = 1'b1;
        INTC_IEND[1] = 1'b1;
        step();
        INTC_IACK[1] = 1'b0;
        INTC_IEND[1] = 1'b0;
        seen = INTC_IRQ[1];
        for (int k = 0; k < 6; k++) begin
            step();
            if (INTC_IRQ[1]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL both_no_rearm got=%b want=0", seen); end
        total++;
        if (OVERRUN[1] !== 1'b1) begin bad++; $display("FAIL both_in_service_overrun got=%b want=1", OVERRUN[1]); end
        iend(1);
        wait_rise(1, 20, n);
        total++;
        if (n != 4) begin bad++; $display("FAIL both_rearm_irq got=%0d want=4", n); end
        cfg(1, 6, 1'b0, 1'b0);
    endtask

    task automatic test_period_one();
        int n;
        bit seen;
        cfg(2, 1, 1'b0, 1'b1);
        wait_rise(2, 10, n);
        total++;
        if (n != 1) begin bad++; $display("FAIL p1_first_irq got=%0d want=1", n); end
        total++;
        if (OVERRUN[2] !== 1'b0) begin bad++; $display("FAIL p1_overrun_early got=%b want=0", OVERRUN[2]); end
        step();
        total++;
        if (OVERRUN[2] !== 1'b1) begin bad++; $display("FAIL p1_overrun got=%b want=1", OVERRUN[2]); end
        ack(2);
        iend(2);
        wait_rise(2, 10, n);
        total++;
        if (n != 1) begin bad++; $display("FAIL p1_rearm_irq got=%0d want=1", n); end
        cfg(2, 0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (INTC_IRQ[2]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL p0_halted got=%b want=0", seen); end
    endtask

    task automatic test_reset_mid_service();
        int n;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        wait_rise(0, DEF_P + 10, n);
        total++;
        if (n != DEF_P) begin bad++; $display("FAIL rst_ms_first_irq got=%0d want=%0d", n, DEF_P); end
        ack(0);
        cfg(1, 3, 1'b0, 1'b1);
        for (int k = 0; k < 18; k++) step();
        total++;
        if (OVERRUN[0] !== 1'b1) begin bad++; $display("FAIL rst_ms_service_overrun got=%b want=1", OVERRUN[0]); end
        total++;
        if (INTC_IRQ[1] !== 1'b1) begin bad++; $display("FAIL rst_ms_ch1_pending got=%b want=1", INTC_IRQ[1]); end
        RESET = 1'b1;
        step();
        total++;
        if (INTC_IRQ !== 3'b000) begin bad++; $display("FAIL rst_ms_irq got=%b want=000", INTC_IRQ); end
        total++;
        if (OVERRUN !== 3'b000) begin bad++; $display("FAIL rst_ms_overrun got=%b want=000", OVERRUN); end
        RESET = 1'b0;
        wait_rise(0, DEF_P + 10, n);
        total++;
        if (n != DEF_P) begin bad++; $display("FAIL rst_ms_full_period got=%0d want=%0d", n, DEF_P); end
        total++;
        if (INTC_IRQ[2:1] !== 2'b00) begin bad++; $display("FAIL rst_ms_other_irq got=%b want=00", INTC_IRQ[2:1]); end
    endtask

    task automatic test_cfg_out_of_range();
        int n;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        cfg(3, 2, 1'b0, 1'b1);
        wait_rise(0, DEF_P + 10, n);
        total++;
        if (n != DEF_P - 1) begin bad++; $display("FAIL oor_ch0_irq got=%0d want=%0d", n, DEF_P - 1); end
        total++;
        if (INTC_IRQ[2:1] !== 2'b00) begin bad++; $display("FAIL oor_other_irq got=%b want=00", INTC_IRQ[2:1]); end
        total++;
        if (OVERRUN !== 3'b000) begin bad++; $display("FAIL oor_overrun got=%b want=000", OVERRUN); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_overrun();
        test_ack_end_together();
        test_period_one();
        test_reset_mid_service();
        test_cfg_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
